// File: rtl/rv_plic_target_pkg.sv
// Shared types and helpers for the PLIC per-target claim/complete controller.
//   state_e       : scan FSM states (SCAN, PUBLISH)
//   MAX_SRC       : upper bound on source count handled by the decode helper
//   id_width()    : ID width for a given source count (ID 0 reserved for "none")
//   id_to_onehot(): ID -> one-hot source vector; out-of-range IDs decode to 0
package rv_plic_target_pkg;

    typedef enum logic {
        SCAN    = 1'b0,
        PUBLISH = 1'b1
    } state_e;

    // PLIC architectural maximum is 1023 sources.
    localparam int unsigned MAX_SRC = 1024;

    function automatic int unsigned id_width(input int unsigned n_source);
        return $clog2(n_source + 1);
    endfunction

    // Bit i is set for ID i+1. IDs of 0 or above n_source yield all-zero,
    // which is how both the claim and complete paths drop invalid IDs.
    function automatic logic [MAX_SRC-1:0] id_to_onehot(input logic [31:0]   id,
                                                        input int unsigned   n_source);
        logic [MAX_SRC-1:0] oh;
        oh = '0;
        for (int unsigned i = 0; i < MAX_SRC; i++) begin
            if (i < n_source && id == i + 1) oh[i] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/rv_plic_prio_cmp.sv
// Priority comparator: returns the incumbent unless the candidate is valid
// and has strictly greater priority. Feeding lower IDs on the incumbent side
// therefore makes ties resolve to the lower ID.
//   inc_prio/inc_id    : current best
//   cand_valid/prio/id : challenger
//   win_prio/win_id    : winner
module rv_plic_prio_cmp #(
    parameter int unsigned PRIO_W = 3,
    parameter int unsigned ID_W   = 6
) (
    input  logic [PRIO_W-1:0] inc_prio,
    input  logic [ID_W-1:0]   inc_id,
    input  logic              cand_valid,
    input  logic [PRIO_W-1:0] cand_prio,
    input  logic [ID_W-1:0]   cand_id,
    output logic [PRIO_W-1:0] win_prio,
    output logic [ID_W-1:0]   win_id
);

    logic take;
    assign take     = cand_valid && (cand_prio > inc_prio);
    assign win_prio = take ? cand_prio : inc_prio;
    assign win_id   = take ? cand_id   : inc_id;

endmodule

// File: rtl/rv_plic_target_ctrl.sv
// Per-target PLIC claim/complete controller.
// Picks the highest-priority pending+enabled source above threshold and
// presents it on irq_o/irq_id_o; turns claim reads and complete writes into
// one-cycle one-hot pulses for the gateways.
//   clk_i, rst_ni         : clock, synchronous active-low reset
//   ip_i, ie_i, prio_i    : gateway pending, target enables, packed priorities
//   threshold_i           : target threshold
//   claim_re_i/claim_id_o : claim read strobe / ID returned same cycle
//   complete_we_i/_id_i   : complete write strobe / written ID
//   claim_o, complete_o   : registered one-hot pulses to gateways
//   irq_o, irq_id_o       : interrupt request and winning ID
// Build option: RV_PLIC_TARGET_PARALLEL_ARB_EN selects a combinational max
// tree registered every cycle instead of the default one-source-per-cycle scan.
module rv_plic_target_ctrl
    import rv_plic_target_pkg::*;
#(
    parameter int unsigned N_SOURCE = 32,
    parameter int unsigned PRIO_W   = 3,
    parameter int unsigned ID_W     = id_width(N_SOURCE)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [N_SOURCE-1:0]        ip_i,
    input  logic [N_SOURCE-1:0]        ie_i,
    input  logic [N_SOURCE*PRIO_W-1:0] prio_i,
    input  logic [PRIO_W-1:0]          threshold_i,
    input  logic                       claim_re_i,
    output logic [ID_W-1:0]            claim_id_o,
    input  logic                       complete_we_i,
    input  logic [ID_W-1:0]            complete_id_i,
    output logic [N_SOURCE-1:0]        claim_o,
    output logic [N_SOURCE-1:0]        complete_o,
    output logic                       irq_o,
    output logic [ID_W-1:0]            irq_id_o
);

    logic [PRIO_W-1:0] prio_arr [N_SOURCE];
    logic              claim_hit;

    for (genvar i = 0; i < N_SOURCE; i++) begin : g_prio
        assign prio_arr[i] = prio_i[i*PRIO_W +: PRIO_W];
    end

    // A claim with nothing to hand out is a no-op: no pulse, no restart.
    assign claim_id_o = irq_id_o;
    assign claim_hit  = claim_re_i && (irq_id_o != '0);

    // Claim/complete pulse generation is identical in both arbiter builds.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            claim_o    <= '0;
            complete_o <= '0;
        end else begin
            claim_o    <= claim_hit ? N_SOURCE'(id_to_onehot(32'(irq_id_o), N_SOURCE)) : '0;
            complete_o <= complete_we_i ? N_SOURCE'(id_to_onehot(32'(complete_id_i), N_SOURCE)) : '0;
        end
    end

`ifdef RV_PLIC_TARGET_PARALLEL_ARB_EN

    // Heap-ordered max tree: node k combines 2k (lower IDs, incumbent) and
    // 2k+1 (candidate). Leaves beyond N_SOURCE are padded with prio 0.
    localparam int unsigned NPOW = 1 << $clog2(N_SOURCE);

    logic [PRIO_W-1:0] node_prio [1:2*NPOW-1];
    logic [ID_W-1:0]   node_id   [1:2*NPOW-1];

    for (genvar i = 0; i < NPOW; i++) begin : g_leaf
        if (i < N_SOURCE) begin : g_src
            logic act;
            assign act                = ip_i[i] & ie_i[i];
            assign node_prio[NPOW+i] = act ? prio_arr[i] : '0;
            assign node_id[NPOW+i]   = act ? ID_W'(i + 1) : '0;
        end else begin : g_pad
            assign node_prio[NPOW+i] = '0;
            assign node_id[NPOW+i]   = '0;
        end
    end

    for (genvar k = 1; k < NPOW; k++) begin : g_node
        rv_plic_prio_cmp #(.PRIO_W(PRIO_W), .ID_W(ID_W)) u_cmp (
            .inc_prio   (node_prio[2*k]),
            .inc_id     (node_id[2*k]),
            .cand_valid (1'b1),
            .cand_prio  (node_prio[2*k+1]),
            .cand_id    (node_id[2*k+1]),
            .win_prio   (node_prio[k]),
            .win_id     (node_id[k])
        );
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || claim_hit) begin
            irq_o    <= 1'b0;
            irq_id_o <= '0;
        end else begin
            irq_o    <= node_prio[1] > threshold_i;
            irq_id_o <= (node_prio[1] > threshold_i) ? node_id[1] : '0;
        end
    end

`else

    localparam int unsigned IDX_W = (N_SOURCE > 1) ? $clog2(N_SOURCE) : 1;

    state_e            state;
    logic [IDX_W-1:0]  idx;
    logic [PRIO_W-1:0] best_prio, win_prio;
    logic [ID_W-1:0]   best_id, win_id;

    // best_prio starts at 0, so priority-0 sources can never win.
    rv_plic_prio_cmp #(.PRIO_W(PRIO_W), .ID_W(ID_W)) u_cmp (
        .inc_prio   (best_prio),
        .inc_id     (best_id),
        .cand_valid (ip_i[idx] & ie_i[idx]),
        .cand_prio  (prio_arr[idx]),
        .cand_id    (ID_W'(idx) + ID_W'(1)),
        .win_prio   (win_prio),
        .win_id     (win_id)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state     <= SCAN;
            idx       <= '0;
            best_prio <= '0;
            best_id   <= '0;
            irq_o     <= 1'b0;
            irq_id_o  <= '0;
        end else if (claim_hit) begin
            // Claim wins over PUBLISH and discards any partial scan, so the
            // claimed source is re-evaluated only after its ip has dropped.
            state     <= SCAN;
            idx       <= '0;
            best_prio <= '0;
            best_id   <= '0;
            irq_o     <= 1'b0;
            irq_id_o  <= '0;
        end else begin
            case (state)
                SCAN: begin
                    best_prio <= win_prio;
                    best_id   <= win_id;
                    if (idx == IDX_W'(N_SOURCE - 1)) state <= PUBLISH;
                    else                             idx   <= idx + IDX_W'(1);
                end
                PUBLISH: begin
                    irq_o     <= best_prio > threshold_i;
                    irq_id_o  <= (best_prio > threshold_i) ? best_id : '0;
                    best_prio <= '0;
                    best_id   <= '0;
                    idx       <= '0;
                    state     <= SCAN;
                end
                default: state <= SCAN;
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_rv_plic_target_ctrl.sv
module tb_rv_plic_target_ctrl;

    localparam int N = 8;
    localparam int PW = 3;
    localparam int IW = 4;

    logic            clk = 1'b0;
    logic            rst_ni = 1'b0;
    logic [N-1:0]    ip = '0, ie = '0;
    logic [N*PW-1:0] prio = '0;
    logic [PW-1:0]   thr = '0;
    logic            claim_re = 1'b0, complete_we = 1'b0;
    logic [IW-1:0]   complete_id = '0;
    logic [IW-1:0]   claim_id, irq_id;
    logic [N-1:0]    claim_v, complete_v;
    logic            irq;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rv_plic_target_ctrl #(.N_SOURCE(N), .PRIO_W(PW)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .ip_i(ip), .ie_i(ie), .prio_i(prio),
        .threshold_i(thr), .claim_re_i(claim_re), .claim_id_o(claim_id),
        .complete_we_i(complete_we), .complete_id_i(complete_id),
        .claim_o(claim_v), .complete_o(complete_v), .irq_o(irq), .irq_id_o(irq_id)
    );

    typedef struct {
        string           name;
        logic [N-1:0]    ip, ie;
        logic [N*PW-1:0] prio;
        logic [PW-1:0]   thr;
        logic            irq;
        logic [IW-1:0]   id;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [N*PW-1:0] pk(input int a, input int pa, input int b, input int pb);
        logic [N*PW-1:0] r;
        r = (24'(pa) << (3 * a)) | (24'(pb) << (3 * b));
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{"basic",       8'h14, 8'hFF, pk(2,3,4,5), 3'd0, 1'b1, 4'd5};
        vecs[1] = '{"thr_eq",      8'h14, 8'hFF, pk(2,3,4,5), 3'd5, 1'b0, 4'd0};
        vecs[2] = '{"thr_below",   8'h14, 8'hFF, pk(2,3,4,5), 3'd4, 1'b1, 4'd5};
        vecs[3] = '{"tie",         8'h42, 8'hFF, pk(1,2,6,2), 3'd0, 1'b1, 4'd2};
        vecs[4] = '{"tie_thr",     8'h42, 8'hFF, pk(1,2,6,2), 3'd2, 1'b0, 4'd0};
        vecs[5] = '{"ie_mask",     8'h14, 8'h04, pk(2,3,4,5), 3'd0, 1'b1, 4'd3};
        vecs[6] = '{"prio_zero",   8'h01, 8'hFF, pk(0,0,1,0), 3'd0, 1'b0, 4'd0};
        vecs[7] = '{"last_src",    8'hFF, 8'hFF, 24'hFAC688,  3'd6, 1'b1, 4'd8};
        vecs[8] = '{"first_src",   8'h01, 8'hFF, pk(0,7,1,0), 3'd6, 1'b1, 4'd1};
        vecs[9] = '{"thr_max",     8'h01, 8'hFF, pk(0,7,1,0), 3'd7, 1'b0, 4'd0};

        // Reset state
        cyc(2);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_irq_id", 32'(irq_id), 0);
        chk("rst_claim_id", 32'(claim_id), 0);
        chk("rst_claim", 32'(claim_v), 0);
        chk("rst_complete", 32'(complete_v), 0);
        rst_ni = 1'b1;

        // Arbitration vectors: 20 cycles covers two full 9-cycle scan periods
        for (int i = 0; i < 10; i++) begin
            ip = vecs[i].ip; ie = vecs[i].ie; prio = vecs[i].prio; thr = vecs[i].thr;
            cyc(20);
            chk({vecs[i].name, "_irq"}, 32'(irq), 32'(vecs[i].irq));
            chk({vecs[i].name, "_id"}, 32'(irq_id), 32'(vecs[i].id));
            chk({vecs[i].name, "_claim_id"}, 32'(claim_id), 32'(vecs[i].id));
        end

        // Claim of ID 5, gateway drops ip[4] once it sees the pulse
        ip = 8'h14; ie = 8'hFF; prio = pk(2,3,4,5); thr = 3'd0;
        cyc(20);
        chk("pre_claim_id", 32'(irq_id), 5);
        claim_re = 1'b1;
        #1 chk("claim_id_comb", 32'(claim_id), 5);
        cyc(1);
        chk("claim_pulse", 32'(claim_v), 32'h10);
        chk("claim_irq_drop", 32'(irq), 0);
        chk("claim_id_drop", 32'(irq_id), 0);
        claim_re = 1'b0;
        ip = 8'h04;
        cyc(1);
        chk("claim_one_cycle", 32'(claim_v), 0);
`ifdef RV_PLIC_TARGET_PARALLEL_ARB_EN
        chk("next_winner", 32'(irq_id), 3);
`else
        cyc(7);
        chk("restart_quiet", 32'(irq), 0);
        cyc(1);
        chk("next_winner", 32'(irq_id), 3);
        chk("next_irq", 32'(irq), 1);
`endif

        // Claim with nothing pending above threshold
        thr = 3'd7;
        cyc(20);
        chk("idle_id", 32'(irq_id), 0);
        claim_re = 1'b1;
        #1 chk("idle_claim_id", 32'(claim_id), 0);
        cyc(1);
        chk("idle_no_pulse", 32'(claim_v), 0);
        claim_re = 1'b0;

        // Complete with out-of-range and boundary IDs
        complete_we = 1'b1; complete_id = 4'd0;
        cyc(1);
        chk("complete_id0", 32'(complete_v), 0);
        complete_id = 4'd9;
        cyc(1);
        chk("complete_id9", 32'(complete_v), 0);
        complete_id = 4'd8;
        cyc(1);
        chk("complete_id8", 32'(complete_v), 32'h80);
        complete_we = 1'b0;
        cyc(1);
        chk("complete_one_cycle", 32'(complete_v), 0);

        // Simultaneous claim and complete on the same source
        ip = 8'h14; thr = 3'd0;
        cyc(20);
        chk("both_pre_id", 32'(irq_id), 5);
        claim_re = 1'b1; complete_we = 1'b1; complete_id = 4'd5;
        cyc(1);
        chk("both_claim", 32'(claim_v), 32'h10);
        chk("both_complete", 32'(complete_v), 32'h10);
        claim_re = 1'b0; complete_we = 1'b0;
        cyc(1);
        chk("both_claim_end", 32'(claim_v), 0);
        chk("both_complete_end", 32'(complete_v), 0);

        // Reset mid-scan together with a claim and a complete
        cyc(20);
        chk("rst2_pre_id", 32'(irq_id), 5);
        cyc(4);
        rst_ni = 1'b0; claim_re = 1'b1; complete_we = 1'b1; complete_id = 4'd3;
        cyc(1);
        chk("rst2_irq", 32'(irq), 0);
        chk("rst2_irq_id", 32'(irq_id), 0);
        chk("rst2_claim", 32'(claim_v), 0);
        chk("rst2_complete", 32'(complete_v), 0);
        rst_ni = 1'b1; claim_re = 1'b0; complete_we = 1'b0;
        cyc(1);
        chk("rst2_no_claim", 32'(claim_v), 0);
        chk("rst2_no_complete", 32'(complete_v), 0);
        cyc(20);
        chk("rst2_recover", 32'(irq_id), 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
